instr_fetch_stage: RTL and testbench

- Fetch stage directly upstream of the instruction decoder in the MIPS core.
- Holds the PC and issues word fetches to instruction memory over a req/ready handshake.
- Captures each returned word into an IF/ID register whose opcode field drives the decoder's instr_op_i.
- Handles downstream stall and branch redirect/flush, using Branch_o qualified by ALU zero as branch_taken_i.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/ifid_reg.sv | 40 ++++
 rtl/instr_fetch_stage.sv | 89 ++++++++
 tb/tb_instr_fetch_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, default reset/NOP words, fetch FSM encoding
// and the IF/ID payload layout.
package mips_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] LUI    = 6'h0F;

  // sll $0,$0,0: decodes as R-type with no architectural effect
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_DROP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  function automatic logic [5:0] opcode(input logic [31:0] w);
    return w[31:26];
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Priority: reset > flush > load > hold; an unheld,
// unloaded register drops to a bubble because decode consumed its contents.
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  ifid_t       d_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  ifid_t q;
  logic  vld;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q   <= '{instr: NOP_INSTR, pc_plus4: 32'h0};
      vld <= 1'b0;
    end else if (flush_i) begin
      vld <= 1'b0;
    end else if (load_i) begin
      q   <= d_i;
      vld <= 1'b1;
    end else if (!hold_i) begin
      vld <= 1'b0;
    end
  end

  assign instr_o    = vld ? q.instr : NOP_INSTR;
  assign pc_plus4_o = q.pc_plus4;
  assign valid_o    = vld;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: owns the PC, issues word fetches over req/ready and fills IF/ID.
// S_DROP drains a request that was already raised when a redirect arrived.
module instr_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [5:0]  instr_op_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  held_addr;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         can_take;
  logic         xfer;
  logic         load;
  ifid_t        ifid_d;

  assign target   = word_align(branch_target_i);
  assign pc_plus4 = pc + 32'd4;
  assign can_take = !valid_o || !stall_i;

  // A pending drop must complete even under stall, since a raised req cannot be withdrawn.
  assign imem_req_o  = !rst_i && ((state == S_DROP) || can_take);
  assign imem_addr_o = rst_i ? RESET_PC : ((state == S_DROP) ? held_addr : pc);
  assign xfer        = imem_req_o && imem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      held_addr <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (branch_taken_i) begin
            pc <= target;
            if (imem_req_o && !imem_ready_i) begin
              held_addr <= pc;
              state     <= S_DROP;
            end
          end else if (xfer) begin
            pc <= pc_plus4;
          end
        end
        S_DROP: begin
          if (branch_taken_i) pc <= target;
          if (xfer) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign load   = xfer && (state == S_REQ) && !branch_taken_i;
  assign ifid_d = '{instr: imem_rdata_i, pc_plus4: pc_plus4};

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .hold_i     (stall_i),
    .flush_i    (branch_taken_i),
    .d_i        (ifid_d),
    .instr_o    (instr_o),
    .pc_plus4_o (pc_plus4_o),
    .valid_o    (valid_o)
  );

  assign instr_op_o = opcode(instr_o);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed cycle checks, then random stall/ready/redirect
// traffic checked against the architectural instruction stream via a scoreboard.
module tb_instr_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, branch_taken_i, imem_ready_i;
  logic [31:0] branch_target_i, imem_rdata_i, imem_addr_o, instr_o, pc_plus4_o;
  logic        imem_req_o, valid_o;
  logic [5:0]  instr_op_o;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h0000_0000;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  instr_fetch_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_o         (instr_o),
    .instr_op_o      (instr_op_o),
    .pc_plus4_o      (pc_plus4_o),
    .valid_o         (valid_o)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int consumed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural stream model: the next instructions decode should receive, in order.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t        sbq[$];
  logic [31:0] model_pc;
  bit          sb_en = 1'b0;

  task automatic refill();
    exp_t e;
    while (sbq.size() < 8) begin
      e.instr = mem_word(model_pc);
      e.pc4   = model_pc + 32'd4;
      sbq.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic redirect_model(input logic [31:0] t);
    sbq.delete();
    model_pc = {t[31:2], 2'b00};
    refill();
  endtask

  // Monitor: handshake stability and in-order delivery of the expected stream.
  logic        p_req = 1'b0, p_rdy = 1'b0;
  logic [31:0] p_addr = 32'h0;
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (p_req && !p_rdy && !rst_i) begin
      chk("req_held", {31'b0, imem_req_o}, 32'h1);
      chk("addr_held", imem_addr_o, p_addr);
    end
    p_req  = imem_req_o && !rst_i;
    p_rdy  = imem_ready_i;
    p_addr = imem_addr_o;
    if (sb_en && !rst_i) begin
      if (!valid_o) begin
        chk("nop_when_invalid", instr_o, 32'h0);
      end else if (!stall_i && !branch_taken_i) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: got instr %h expected none queued", instr_o);
        end else begin
          e = sbq.pop_front();
          chk("sb_instr", instr_o, e.instr);
          chk("sb_pc_plus4", pc_plus4_o, e.pc4);
          chk("sb_op", {26'b0, instr_op_o}, {26'b0, e.instr[31:26]});
          consumed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = 32'h0; imem_ready_i = 1'b1;
    step(); step();
    smp();
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc4", pc_plus4_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);

    step(); rst_i = 1'b0;
    smp();
    chk("first_req", {31'b0, imem_req_o}, 32'h1);
    chk("first_addr", imem_addr_o, 32'h0);

    step(); stall_i = 1'b1;
    smp();
    chk("w0_valid", {31'b0, valid_o}, 32'h1);
    chk("w0_instr", instr_o, 32'h2008_0005);
    chk("w0_op", {26'b0, instr_op_o}, 32'h8);
    chk("w0_pc4", pc_plus4_o, 32'h4);
    chk("stall_req", {31'b0, imem_req_o}, 32'h0);

    for (int i = 0; i < 2; i++) begin
      step();
      smp();
      chk("stall_instr", instr_o, 32'h2008_0005);
      chk("stall_pc4", pc_plus4_o, 32'h4);
      chk("stall_req_low", {31'b0, imem_req_o}, 32'h0);
      chk("stall_addr", imem_addr_o, 32'h4);
    end
    step(); stall_i = 1'b0;
    smp();
    chk("unstall_instr", instr_o, 32'h2008_0005);
    chk("resume_req", {31'b0, imem_req_o}, 32'h1);
    chk("resume_addr", imem_addr_o, 32'h4);

    step(); branch_taken_i = 1'b1; branch_target_i = 32'h40;
    smp();
    chk("w1_pc4", pc_plus4_o, 32'h8);
    chk("w1_instr", instr_o, 32'h0);

    step(); branch_taken_i = 1'b0;
    smp();
    chk("redir_valid", {31'b0, valid_o}, 32'h0);
    chk("redir_addr", imem_addr_o, 32'h40);

    step(); branch_taken_i = 1'b1; branch_target_i = 32'h8;
    smp();
    chk("tgt_valid", {31'b0, valid_o}, 32'h1);
    chk("tgt_pc4", pc_plus4_o, 32'h44);
    chk("tgt_instr", instr_o, mem_word(32'h40));

    step(); branch_taken_i = 1'b1; branch_target_i = 32'h80; imem_ready_i = 1'b0;
    smp();
    chk("pre_drop_addr", imem_addr_o, 32'h8);
    chk("pre_drop_valid", {31'b0, valid_o}, 32'h0);

    step(); branch_taken_i = 1'b0;
    smp();
    chk("drop_addr0", imem_addr_o, 32'h8);
    chk("drop_req0", {31'b0, imem_req_o}, 32'h1);

    step(); imem_ready_i = 1'b1;
    smp();
    chk("drop_addr1", imem_addr_o, 32'h8);

    step();
    smp();
    chk("post_drop_addr", imem_addr_o, 32'h80);
    chk("post_drop_valid", {31'b0, valid_o}, 32'h0);

    step(); stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h43;
    smp();
    chk("w80_pc4", pc_plus4_o, 32'h84);

    step(); branch_taken_i = 1'b0;
    smp();
    chk("flush_stall_valid", {31'b0, valid_o}, 32'h0);
    chk("align_addr", imem_addr_o, 32'h40);
    chk("flush_stall_req", {31'b0, imem_req_o}, 32'h1);

    step(); stall_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    smp();
    chk("load_under_stall", {31'b0, valid_o}, 32'h1);

    step(); branch_taken_i = 1'b0;
    smp();
    chk("top_addr", imem_addr_o, 32'hFFFF_FFFC);

    step(); imem_ready_i = 1'b0;
    smp();
    chk("wrap_pc4", pc_plus4_o, 32'h0);
    chk("wrap_instr", instr_o, mem_word(32'hFFFF_FFFC));
    chk("wrap_addr", imem_addr_o, 32'h0);

    step(); rst_i = 1'b1;
    smp();
    chk("rst_mid_req", {31'b0, imem_req_o}, 32'h0);
    step();
    smp();
    chk("rst_mid_addr", imem_addr_o, 32'h0);
    chk("rst_mid_valid", {31'b0, valid_o}, 32'h0);

    step();
    rst_i = 1'b0; imem_ready_i = 1'b1;
    redirect_model(32'h0);
    sb_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      stall_i      = ($urandom % 4) == 0;
      imem_ready_i = ($urandom % 4) != 0;
      if (($urandom % 12) == 0) begin
        branch_taken_i  = 1'b1;
        branch_target_i = ($urandom % 8 == 0) ? 32'hFFFF_FFF0 | ($urandom % 16) : $urandom;
        redirect_model(branch_target_i);
      end else begin
        branch_taken_i = 1'b0;
      end
      refill();
    end
    step();
    sb_en = 1'b0;
    chk("progress", {31'b0, consumed > 200}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
